// File: rtl/riscv_v_pkg.sv
// ---------------------------------------------------------------------------
// riscv_v_pkg
// Shared types and helpers for the vector CSR slice: vtype layout, SEW/LMUL
// encodings, vsstatus.VS encoding, the vsetvl sequencer states and the
// VLMAX helper used by both the legality checker and the CSR file.
// ---------------------------------------------------------------------------
package riscv_v_pkg;

  localparam int XLEN         = 32;
  localparam int VLEN         = 128;
  localparam int ELEN         = 32;
  localparam int VS_FIELD_LSB = 9;

  typedef enum logic [2:0] {
    SEW_8  = 3'd0,
    SEW_16 = 3'd1,
    SEW_32 = 3'd2,
    SEW_64 = 3'd3
  } vsew_e;

  typedef enum logic [2:0] {
    LMUL_1    = 3'd0,
    LMUL_2    = 3'd1,
    LMUL_4    = 3'd2,
    LMUL_8    = 3'd3,
    LMUL_RSVD = 3'd4,
    LMUL_F8   = 3'd5,
    LMUL_F4   = 3'd6,
    LMUL_F2   = 3'd7
  } vlmul_e;

  typedef enum logic [1:0] {
    VS_OFF     = 2'b00,
    VS_INITIAL = 2'b01,
    VS_CLEAN   = 2'b10,
    VS_DIRTY   = 2'b11
  } vs_state_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } vset_state_e;

  typedef struct packed {
    logic              vill;
    logic [XLEN-10:0]  reserved;
    logic              vma;
    logic              vta;
    vsew_e             vsew;
    vlmul_e            vlmul;
  } vtype_t;

  // VLMAX = (VLEN/SEW)*LMUL. Fractional LMUL encodings (5,6,7) divide by
  // 8,4,2, i.e. shift right by (8 - vlmul). Only meaningful for legal vtypes.
  function automatic logic [31:0] vlmax_f(input vtype_t vt, input int unsigned vlen);
    logic [31:0] elems;
    logic [2:0]  lmul;
    elems = vlen >> (32'd3 + 32'(vt.vsew));
    lmul  = vt.vlmul;
    if (lmul[2]) vlmax_f = elems >> (4'd8 - {1'b0, lmul});
    else         vlmax_f = elems << lmul;
  endfunction

endpackage

// File: rtl/riscv_v_vtype_check.sv
// ---------------------------------------------------------------------------
// riscv_v_vtype_check
// Purely combinational vtype legality check.
//   i_vtype  : raw requested vtype
//   o_legal  : 1 when SEW/LMUL are supported and reserved bits are zero
//   o_vtype  : value to store (vill-only when illegal, vill cleared otherwise)
//   o_vlmax  : VLMAX for the requested vtype, 0 when illegal
// ---------------------------------------------------------------------------
module riscv_v_vtype_check
  import riscv_v_pkg::*;
#(
  parameter int XLEN = riscv_v_pkg::XLEN,
  parameter int VLEN = riscv_v_pkg::VLEN,
  parameter int ELEN = riscv_v_pkg::ELEN,
  parameter int VL_W = $clog2(VLEN) + 1
) (
  input  logic [XLEN-1:0] i_vtype,
  output logic            o_legal,
  output logic [XLEN-1:0] o_vtype,
  output logic [VL_W-1:0] o_vlmax
);

  localparam logic [2:0] MAX_VSEW = 3'($clog2(ELEN / 8));

  vtype_t      w_vt;
  logic [2:0]  w_vsew;
  logic [2:0]  w_lmul;
  logic [31:0] w_sewBits;
  logic [31:0] w_fracLimit;

  assign w_vt        = vtype_t'(i_vtype);
  assign w_vsew      = w_vt.vsew;
  assign w_lmul      = w_vt.vlmul;
  assign w_sewBits   = 32'd8 << w_vsew;
  // ELEN*LMUL for fractional LMUL; a fractional group must still hold one element
  assign w_fracLimit = 32'(ELEN) >> (4'd8 - {1'b0, w_lmul});

  // Any single failing condition makes the whole vtype illegal
  always_comb begin
    o_legal = 1'b1;
    if (w_vsew > MAX_VSEW)                   o_legal = 1'b0;
    if (w_lmul == 3'b100)                    o_legal = 1'b0;
    if (w_lmul[2] && (w_sewBits > w_fracLimit)) o_legal = 1'b0;
    if (|w_vt.reserved)                      o_legal = 1'b0;
  end

  assign o_vtype = o_legal ? {1'b0, {(XLEN-9){1'b0}}, i_vtype[7:0]}
                           : {1'b1, {(XLEN-1){1'b0}}};
  assign o_vlmax = o_legal ? VL_W'(vlmax_f(w_vt, VLEN)) : '0;

endmodule

// File: rtl/riscv_v_csr_file.sv
// ---------------------------------------------------------------------------
// riscv_v_csr_file
// Architectural vector CSR state: vsstatus.VS, vtype, vl, vstart, vxrm, vxsat.
//   i_clk / i_rst_n          : clock, asynchronous active-low reset
//   i_ext_csr_data, i_ext_wr_*: CSR write bus from the scalar CSR unit
//   i_vset_* / o_vset_*      : vsetvl{i}/vsetivli request and registered result
//   i_vstart_*, i_vxsat_set  : side-effects from the vector execution units
//   o_*_q, o_vs_state, o_vs_off : current state broadcast to decode/execute
// ---------------------------------------------------------------------------
module riscv_v_csr_file
  import riscv_v_pkg::*;
#(
  parameter int XLEN = riscv_v_pkg::XLEN,
  parameter int VLEN = riscv_v_pkg::VLEN,
  parameter int ELEN = riscv_v_pkg::ELEN,
  parameter int VL_W = $clog2(VLEN) + 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] i_ext_csr_data,
  input  logic            i_ext_wr_vsstatus,
  input  logic            i_ext_wr_vtype,
  input  logic            i_ext_wr_vl,
  input  logic            i_ext_wr_vstart,
  input  logic            i_ext_wr_vxrm,
  input  logic            i_ext_wr_vxsat,
  input  logic            i_vset_valid,
  output logic            o_vset_ready,
  input  logic [XLEN-1:0] i_vset_avl,
  input  logic [XLEN-1:0] i_vset_vtype,
  input  logic            i_vset_rs1_x0,
  input  logic            i_vset_rd_x0,
  output logic            o_vset_rsp_valid,
  output logic [XLEN-1:0] o_vset_rsp_vl,
  input  logic            i_vstart_wr,
  input  logic [VL_W-1:0] i_vstart_wdata,
  input  logic            i_vstart_clr,
  input  logic            i_vxsat_set,
  output logic [1:0]      o_vs_state,
  output logic [XLEN-1:0] o_vtype_q,
  output logic [VL_W-1:0] o_vl_q,
  output logic [VL_W-1:0] o_vstart_q,
  output logic [1:0]      o_vxrm_q,
  output logic            o_vxsat_q,
  output logic [VL_W-1:0] o_vlmax_q,
  output logic            o_vs_off
);

  localparam logic [XLEN-1:0] VILL_ONLY = {1'b1, {(XLEN-1){1'b0}}};

  vset_state_e     r_state;
  logic            r_ready;
  logic            r_rspValid;
  logic [XLEN-1:0] r_rspVl;
  logic [XLEN-1:0] r_reqAvl;
  logic [XLEN-1:0] r_reqVtype;
  logic            r_reqRs1X0;
  logic            r_reqRdX0;

  vs_state_e       r_vs;
  logic [XLEN-1:0] r_vtype;
  logic [VL_W-1:0] r_vl;
  logic [VL_W-1:0] r_vstart;
  logic [1:0]      r_vxrm;
  logic            r_vxsat;

  logic            w_extLegal;
  logic [XLEN-1:0] w_extVtype;
  logic [VL_W-1:0] w_extVlmaxUnused;
  logic            w_vsetLegal;
  logic [XLEN-1:0] w_vsetVtype;
  logic [VL_W-1:0] w_vsetVlmax;
  logic [XLEN-1:0] w_setVtype;
  logic [VL_W-1:0] w_setVl;
  logic            w_commit;
  logic            w_dirty;

  riscv_v_vtype_check #(.XLEN(XLEN), .VLEN(VLEN), .ELEN(ELEN), .VL_W(VL_W)) u_extCheck (
    .i_vtype (i_ext_csr_data),
    .o_legal (w_extLegal),
    .o_vtype (w_extVtype),
    .o_vlmax (w_extVlmaxUnused)
  );

  riscv_v_vtype_check #(.XLEN(XLEN), .VLEN(VLEN), .ELEN(ELEN), .VL_W(VL_W)) u_vsetCheck (
    .i_vtype (r_reqVtype),
    .o_legal (w_vsetLegal),
    .o_vtype (w_vsetVtype),
    .o_vlmax (w_vsetVlmax)
  );

  // The latched request is evaluated during CALC and committed on the edge
  // that leaves CALC, the same edge that raises the response pulse.
  assign w_commit = (r_state == S_CALC);

  // New vtype/vl chosen from the AVL source. With rs1=rd=x0 the old vl is kept,
  // but a vtype whose VLMAX cannot hold it is refused by setting vill.
  always_comb begin
    w_setVtype = w_vsetVtype;
    w_setVl    = '0;
    if (!w_vsetLegal) begin
      w_setVl = '0;
    end else if (r_reqRs1X0 && !r_reqRdX0) begin
      w_setVl = w_vsetVlmax;
    end else if (r_reqRs1X0) begin
      if (w_vsetVlmax < r_vl) begin
        w_setVtype = VILL_ONLY;
        w_setVl    = '0;
      end else begin
        w_setVl = r_vl;
      end
    end else if (r_reqAvl < XLEN'(w_vsetVlmax)) begin
      w_setVl = r_reqAvl[VL_W-1:0];
    end else begin
      w_setVl = w_vsetVlmax;
    end
  end

  // The vsetvl sequencer: accept in IDLE, evaluate in CALC, pulse the response
  // in RESP and then return to IDLE, giving one request every three cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b1;
      r_rspValid <= 1'b0;
      r_rspVl    <= '0;
      r_reqAvl   <= '0;
      r_reqVtype <= '0;
      r_reqRs1X0 <= 1'b0;
      r_reqRdX0  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rspValid <= 1'b0;
          if (i_vset_valid) begin
            r_reqAvl   <= i_vset_avl;
            r_reqVtype <= i_vset_vtype;
            r_reqRs1X0 <= i_vset_rs1_x0;
            r_reqRdX0  <= i_vset_rd_x0;
            r_ready    <= 1'b0;
            r_state    <= S_CALC;
          end
        end
        S_CALC: begin
          r_rspValid <= 1'b1;
          r_rspVl    <= XLEN'(w_setVl);
          r_state    <= S_RESP;
        end
        S_RESP: begin
          r_rspValid <= 1'b0;
          r_ready    <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: begin
          r_rspValid <= 1'b0;
          r_ready    <= 1'b1;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  // Only internal updates that actually land mark the vector state dirty;
  // an external write to the same field same cycle overrides them.
  assign w_dirty = w_commit
                 | ((i_vstart_wr | i_vstart_clr) & ~i_ext_wr_vstart)
                 | (i_vxsat_set & ~i_ext_wr_vxsat);

  // Architectural CSR fields, each with its own priority chain:
  // external write, then vsetvl commit, then execution-unit side-effects.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vs     <= VS_INITIAL;
      r_vtype  <= VILL_ONLY;
      r_vl     <= '0;
      r_vstart <= '0;
      r_vxrm   <= '0;
      r_vxsat  <= 1'b0;
    end else begin
      if (i_ext_wr_vtype)   r_vtype <= w_extVtype;
      else if (w_commit)    r_vtype <= w_setVtype;

      if (i_ext_wr_vl)                       r_vl <= i_ext_csr_data[VL_W-1:0];
      else if (i_ext_wr_vtype && !w_extLegal) r_vl <= '0;
      else if (w_commit)                     r_vl <= w_setVl;

      if (i_ext_wr_vstart)   r_vstart <= i_ext_csr_data[VL_W-1:0];
      else if (w_commit)     r_vstart <= '0;
      else if (i_vstart_wr)  r_vstart <= i_vstart_wdata;
      else if (i_vstart_clr) r_vstart <= '0;

      if (i_ext_wr_vxrm) r_vxrm <= i_ext_csr_data[1:0];

      if (i_ext_wr_vxsat) r_vxsat <= i_ext_csr_data[0];
      else                r_vxsat <= r_vxsat | i_vxsat_set;

      if (i_ext_wr_vsstatus)
        r_vs <= vs_state_e'(i_ext_csr_data[VS_FIELD_LSB+1:VS_FIELD_LSB]);
      else if (w_dirty && (r_vs != VS_OFF))
        r_vs <= VS_DIRTY;
    end
  end

  assign o_vset_ready     = r_ready;
  assign o_vset_rsp_valid = r_rspValid;
  assign o_vset_rsp_vl    = r_rspVl;
  assign o_vs_state       = r_vs;
  assign o_vtype_q        = r_vtype;
  assign o_vl_q           = r_vl;
  assign o_vstart_q       = r_vstart;
  assign o_vxrm_q         = r_vxrm;
  assign o_vxsat_q        = r_vxsat;
  assign o_vs_off         = (r_vs == VS_OFF);
  // Stored vtypes are always sanitized, so vill clear implies a legal encoding
  assign o_vlmax_q        = r_vtype[XLEN-1] ? '0 : VL_W'(vlmax_f(vtype_t'(r_vtype), VLEN));

endmodule

// File: tb/tb_riscv_v_csr_file.sv
// ---------------------------------------------------------------------------
// tb_riscv_v_csr_file
// Directed bench for riscv_v_csr_file: a table of single-cycle CSR
// write/side-effect vectors followed by hand-written vsetvl sequences.
// ---------------------------------------------------------------------------
module tb_riscv_v_csr_file;

  logic        clk;
  logic        rstN;
  logic [31:0] extCsrData;
  logic        extWrVsstatus, extWrVtype, extWrVl, extWrVstart, extWrVxrm, extWrVxsat;
  logic        vsetValid;
  logic        vsetReady;
  logic [31:0] vsetAvl;
  logic [31:0] vsetVtype;
  logic        vsetRs1X0, vsetRdX0;
  logic        vsetRspValid;
  logic [31:0] vsetRspVl;
  logic        vstartWr;
  logic [7:0]  vstartWdata;
  logic        vstartClr;
  logic        vxsatSet;
  logic [1:0]  vsState;
  logic [31:0] vtypeQ;
  logic [7:0]  vlQ, vstartQ, vlmaxQ;
  logic [1:0]  vxrmQ;
  logic        vxsatQ;
  logic        vsOff;

  int vectorCount = 0;
  int missCount   = 0;

  // Strobe order: {vsstatus, vtype, vl, vstart, vxrm, vxsat}
  typedef struct {
    string       name;
    logic [31:0] data;
    logic [5:0]  extWr;
    logic        vstartWr;
    logic [7:0]  vstartWdata;
    logic        vstartClr;
    logic        vxsatSet;
    logic [1:0]  expVs;
    logic [31:0] expVtype;
    logic [7:0]  expVl;
    logic [7:0]  expVstart;
    logic [1:0]  expVxrm;
    logic        expVxsat;
    logic [7:0]  expVlmax;
  } vecRec_t;

  vecRec_t vecs[19];

  riscv_v_csr_file dut (
    .i_clk             (clk),
    .i_rst_n           (rstN),
    .i_ext_csr_data    (extCsrData),
    .i_ext_wr_vsstatus (extWrVsstatus),
    .i_ext_wr_vtype    (extWrVtype),
    .i_ext_wr_vl       (extWrVl),
    .i_ext_wr_vstart   (extWrVstart),
    .i_ext_wr_vxrm     (extWrVxrm),
    .i_ext_wr_vxsat    (extWrVxsat),
    .i_vset_valid      (vsetValid),
    .o_vset_ready      (vsetReady),
    .i_vset_avl        (vsetAvl),
    .i_vset_vtype      (vsetVtype),
    .i_vset_rs1_x0     (vsetRs1X0),
    .i_vset_rd_x0      (vsetRdX0),
    .o_vset_rsp_valid  (vsetRspValid),
    .o_vset_rsp_vl     (vsetRspVl),
    .i_vstart_wr       (vstartWr),
    .i_vstart_wdata    (vstartWdata),
    .i_vstart_clr      (vstartClr),
    .i_vxsat_set       (vxsatSet),
    .o_vs_state        (vsState),
    .o_vtype_q         (vtypeQ),
    .o_vl_q            (vlQ),
    .o_vstart_q        (vstartQ),
    .o_vxrm_q          (vxrmQ),
    .o_vxsat_q         (vxsatQ),
    .o_vlmax_q         (vlmaxQ),
    .o_vs_off          (vsOff)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something stalls the main sequence
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    extCsrData = '0;
    {extWrVsstatus, extWrVtype, extWrVl, extWrVstart, extWrVxrm, extWrVxsat} = '0;
    vsetValid = 1'b0; vsetAvl = '0; vsetVtype = '0; vsetRs1X0 = 1'b0; vsetRdX0 = 1'b0;
    vstartWr = 1'b0; vstartWdata = '0; vstartClr = 1'b0; vxsatSet = 1'b0;
  endtask

  task automatic applyStimulus(input vecRec_t v);
    extCsrData = v.data;
    {extWrVsstatus, extWrVtype, extWrVl, extWrVstart, extWrVxrm, extWrVxsat} = v.extWr;
    vstartWr = v.vstartWr; vstartWdata = v.vstartWdata;
    vstartClr = v.vstartClr; vxsatSet = v.vxsatSet;
    tick();
    clearInputs();
  endtask

  task automatic extWrite(input logic [5:0] strobes, input logic [31:0] data);
    extCsrData = data;
    {extWrVsstatus, extWrVtype, extWrVl, extWrVstart, extWrVxrm, extWrVxsat} = strobes;
    tick();
    clearInputs();
  endtask

  task automatic doReset();
    clearInputs();
    rstN = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
  endtask

  // One vsetvl transaction: accept, CALC, RESP pulse, back to IDLE
  task automatic vsetSequence(input string name, input logic [31:0] avl, input logic [31:0] vt,
                              input logic rs1X0, input logic rdX0, input bit chkVl,
                              input logic [31:0] expVl);
    checkOutput({name, " ready before"}, 32'(vsetReady), 32'd1);
    vsetValid = 1'b1; vsetAvl = avl; vsetVtype = vt; vsetRs1X0 = rs1X0; vsetRdX0 = rdX0;
    tick();
    clearInputs();
    checkOutput({name, " ready in calc"}, 32'(vsetReady), 32'd0);
    checkOutput({name, " no early rsp"}, 32'(vsetRspValid), 32'd0);
    tick();
    checkOutput({name, " rsp valid"}, 32'(vsetRspValid), 32'd1);
    if (chkVl) begin
      checkOutput({name, " rsp vl"}, vsetRspVl, expVl);
      checkOutput({name, " vl_q"}, 32'(vlQ), expVl);
    end
    tick();
    checkOutput({name, " rsp one cycle"}, 32'(vsetRspValid), 32'd0);
    checkOutput({name, " ready after"}, 32'(vsetReady), 32'd1);
  endtask

  initial begin
    rstN = 1'b0;
    clearInputs();

    //          name            data          extWr     vsWr wd  clr set  vs     vtype         vl  vst xrm sat lmax
    vecs[0]  = '{"vxrm write",   32'h3,        6'b000010, 0, 0, 0, 0, 2'b01, 32'h8000_0000, 0,  0,  3, 0, 0};
    vecs[1]  = '{"vxsat ext wins",32'h0,       6'b000001, 0, 0, 0, 1, 2'b01, 32'h8000_0000, 0,  0,  3, 0, 0};
    vecs[2]  = '{"vxsat set",    32'h0,        6'b000000, 0, 0, 0, 1, 2'b11, 32'h8000_0000, 0,  0,  3, 1, 0};
    vecs[3]  = '{"vs initial",   32'h200,      6'b100000, 0, 0, 0, 0, 2'b01, 32'h8000_0000, 0,  0,  3, 1, 0};
    vecs[4]  = '{"vstart ext wins",32'h9,      6'b000100, 1, 5, 0, 0, 2'b01, 32'h8000_0000, 0,  9,  3, 1, 0};
    vecs[5]  = '{"vstart clr",   32'h0,        6'b000000, 0, 0, 1, 0, 2'b11, 32'h8000_0000, 0,  0,  3, 1, 0};
    vecs[6]  = '{"vs off",       32'h0,        6'b100000, 0, 0, 0, 0, 2'b00, 32'h8000_0000, 0,  0,  3, 1, 0};
    vecs[7]  = '{"vstart wr off",32'h0,        6'b000000, 1, 7, 0, 0, 2'b00, 32'h8000_0000, 0,  7,  3, 1, 0};
    vecs[8]  = '{"vtype e16m8",  32'h0B,       6'b010000, 0, 0, 0, 0, 2'b00, 32'h0000_000B, 0,  7,  3, 1, 64};
    vecs[9]  = '{"vl+vxsat",     32'h2A,       6'b001001, 0, 0, 0, 0, 2'b00, 32'h0000_000B, 42, 7,  3, 0, 64};
    vecs[10] = '{"vtype e8mf8",  32'h05,       6'b010000, 0, 0, 0, 0, 2'b00, 32'h8000_0000, 0,  7,  3, 0, 0};
    vecs[11] = '{"vtype e16mf2", 32'h0F,       6'b010000, 0, 0, 0, 0, 2'b00, 32'h0000_000F, 0,  7,  3, 0, 4};
    vecs[12] = '{"vtype e8m2 ma",32'hC1,       6'b010000, 0, 0, 0, 0, 2'b00, 32'h0000_00C1, 0,  7,  3, 0, 32};
    vecs[13] = '{"vtype e64",    32'h18,       6'b010000, 0, 0, 0, 0, 2'b00, 32'h8000_0000, 0,  7,  3, 0, 0};
    vecs[14] = '{"vtype+vl",     32'h0E,       6'b011000, 0, 0, 0, 0, 2'b00, 32'h8000_0000, 14, 7,  3, 0, 0};
    vecs[15] = '{"vtype rsvd",   32'h100,      6'b010000, 0, 0, 0, 0, 2'b00, 32'h8000_0000, 0,  7,  3, 0, 0};
    vecs[16] = '{"vxsat off",    32'h0,        6'b000000, 0, 0, 0, 1, 2'b00, 32'h8000_0000, 0,  7,  3, 1, 0};
    vecs[17] = '{"vs clean",     32'h400,      6'b100000, 0, 0, 0, 0, 2'b10, 32'h8000_0000, 0,  7,  3, 1, 0};
    vecs[18] = '{"vs ext beats dirty",32'h200, 6'b100000, 0, 0, 1, 0, 2'b01, 32'h8000_0000, 0,  0,  3, 1, 0};

    // Reset state
    tick();
    checkOutput("reset vtype", vtypeQ, 32'h8000_0000);
    checkOutput("reset vl", 32'(vlQ), 32'd0);
    checkOutput("reset vs", 32'(vsState), 32'd1);
    checkOutput("reset ready", 32'(vsetReady), 32'd1);
    checkOutput("reset rsp valid", 32'(vsetRspValid), 32'd0);
    checkOutput("reset vlmax", 32'(vlmaxQ), 32'd0);
    tick();
    rstN = 1'b1;
    tick();

    // Table-driven single-cycle vectors
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i]);
      checkOutput({vecs[i].name, " vs"},     32'(vsState), 32'(vecs[i].expVs));
      checkOutput({vecs[i].name, " vtype"},  vtypeQ,       vecs[i].expVtype);
      checkOutput({vecs[i].name, " vl"},     32'(vlQ),     32'(vecs[i].expVl));
      checkOutput({vecs[i].name, " vstart"}, 32'(vstartQ), 32'(vecs[i].expVstart));
      checkOutput({vecs[i].name, " vxrm"},   32'(vxrmQ),   32'(vecs[i].expVxrm));
      checkOutput({vecs[i].name, " vxsat"},  32'(vxsatQ),  32'(vecs[i].expVxsat));
      checkOutput({vecs[i].name, " vlmax"},  32'(vlmaxQ),  32'(vecs[i].expVlmax));
      checkOutput({vecs[i].name, " vs_off"}, 32'(vsOff),   (vecs[i].expVs == 2'b00) ? 32'd1 : 32'd0);
    end

    // vsetvli e32m1 AVL=20, also clears a pending vstart
    doReset();
    extWrite(6'b000100, 32'd5);
    checkOutput("pre vstart", 32'(vstartQ), 32'd5);
    vsetSequence("e32m1 avl20", 32'd20, 32'h10, 1'b0, 1'b0, 1'b1, 32'd4);
    checkOutput("e32m1 vlmax", 32'(vlmaxQ), 32'd4);
    checkOutput("e32m1 vtype", vtypeQ, 32'h10);
    checkOutput("e32m1 vs dirty", 32'(vsState), 32'd3);
    checkOutput("e32m1 vstart clr", 32'(vstartQ), 32'd0);

    // rs1=x0, rd!=x0 -> VLMAX
    vsetSequence("e8m8 vlmax", 32'd0, 32'h03, 1'b1, 1'b0, 1'b1, 32'd128);
    checkOutput("e8m8 vlmax_q", 32'(vlmaxQ), 32'd128);

    // reserved LMUL
    vsetSequence("lmul rsvd", 32'd10, 32'h04, 1'b0, 1'b0, 1'b1, 32'd0);
    checkOutput("lmul rsvd vtype", vtypeQ, 32'h8000_0000);

    // AVL below and far above VLMAX
    vsetSequence("avl small", 32'd2, 32'h10, 1'b0, 1'b0, 1'b1, 32'd2);
    vsetSequence("avl huge", 32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0, 1'b1, 32'd4);

    // rs1=rd=x0 keeps vl when the new VLMAX still holds it, else sets vill
    vsetSequence("e32m2 avl6", 32'd6, 32'h11, 1'b0, 1'b0, 1'b1, 32'd6);
    vsetSequence("keep vl", 32'd99, 32'h11, 1'b1, 1'b1, 1'b1, 32'd6);
    checkOutput("keep vl vtype", vtypeQ, 32'h11);
    vsetSequence("shrink vill", 32'd0, 32'h10, 1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("shrink vill vtype", vtypeQ, 32'h8000_0000);
    checkOutput("shrink vill vlmax", 32'(vlmaxQ), 32'd0);

    // Requests still complete while VS is Off, and VS stays Off
    extWrite(6'b100000, 32'h0);
    vsetSequence("vs off vset", 32'd3, 32'h10, 1'b0, 1'b0, 1'b1, 32'd3);
    checkOutput("vs off kept", 32'(vsState), 32'd0);
    checkOutput("vs off flag", 32'(vsOff), 32'd1);

    // Reset pulse while the request sits in CALC
    vsetValid = 1'b1; vsetAvl = 32'd20; vsetVtype = 32'h10;
    tick();
    clearInputs();
    checkOutput("rst calc ready low", 32'(vsetReady), 32'd0);
    #2 rstN = 1'b0;
    #2;
    checkOutput("rst calc ready", 32'(vsetReady), 32'd1);
    checkOutput("rst calc rsp", 32'(vsetRspValid), 32'd0);
    #1 rstN = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("rst calc no rsp", 32'(vsetRspValid), 32'd0);
    end
    checkOutput("rst calc vl", 32'(vlQ), 32'd0);
    checkOutput("rst calc vtype", vtypeQ, 32'h8000_0000);
    checkOutput("rst calc vs", 32'(vsState), 32'd1);
    vsetSequence("after rst", 32'd20, 32'h10, 1'b0, 1'b0, 1'b1, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/riscv_v_csr_file.md
Name: riscv_v_csr_file

Overview:
Architectural vector CSR state holder for the RISC-V V extension; directly consumes the external CSR write bus (ext_csr_data plus ext_wr_* strobes) driven by the scalar CSR unit. Holds vsstatus.VS, vtype, vl, vstart, vxrm and vxsat. Executes vsetvl/vsetvli/vsetivli through a valid/ready handshake and a registered result. Accepts vstart/vxsat side-effects from the vector execution units and broadcasts current state to decode and execution.

Parameters:
XLEN, 32, scalar data/CSR width (riscv_data_t).
VLEN, 128, vector register length in bits.
ELEN, 32, maximum element width in bits.
VL_W, $clog2(VLEN)+1, width of vl/vlmax fields.

Ports:
clk  in  1  clock.
rst  in  1  reset; asynchronous, active-low (asserted at 0).
ext_csr_data  in  XLEN  external write data.
ext_wr_vsstatus / ext_wr_vtype / ext_wr_vl / ext_wr_vstart / ext_wr_vxrm / ext_wr_vxsat  in  1 each  external write strobes.
vset_valid  in  1  vsetvl request.
vset_ready  out  1  request accepted when valid&ready.
vset_avl  in  XLEN  AVL (rs1 value or uimm).
vset_vtype  in  XLEN  requested vtype.
vset_rs1_x0  in  1  AVL source is x0.
vset_rd_x0  in  1  destination is x0.
vset_rsp_valid  out  1  result pulse.
vset_rsp_vl  out  XLEN  new vl for rd writeback.
vstart_wr  in  1  execution-unit vstart update.
vstart_wdata  in  VL_W  new vstart value.
vstart_clr  in  1  vector instruction retired; clear vstart.
vxsat_set  in  1  saturation occurred.
vs_state  out  2  vsstatus.VS.
vtype_q  out  XLEN  current vtype.
vl_q  out  VL_W  current vl.
vstart_q  out  VL_W  current vstart.
vxrm_q  out  2  current vxrm.
vxsat_q  out  1  current vxsat.
vlmax_q  out  VL_W  VLMAX for current vtype (0 if vill).
vs_off  out  1  VS==Off; decode raises illegal-instruction.

Behaviour:
- Reset values: vs_state=2'b01 (Initial), vtype_q={1'b1 (vill), 0...}, vl_q=0, vstart_q=0, vxrm_q=0, vxsat_q=0, vlmax_q=0, vset_ready=1, vset_rsp_valid=0, vset_rsp_vl=0.
- vtype fields: vill [XLEN-1], vma [7], vta [6], vsew [5:3], vlmul [2:0].
- Illegal vtype: vsew>log2(ELEN/8), vlmul==3'b100, fractional LMUL with SEW > ELEN*LMUL, or reserved bits [XLEN-2:8] nonzero -> stored vtype = vill only, vl=0.
- VLMAX = (VLEN/SEW)*LMUL (LMUL fractional: right shift).
- vsetvl FSM: IDLE (ready=1) -> on valid -> CALC (ready=0, compute registered) -> RESP (rsp_valid=1 one cycle, state committed same edge) -> IDLE. Request-to-response latency 2 cycles; throughput 1 per 3 cycles.
- AVL select: rs1_x0 & !rd_x0 -> vl=VLMAX; rs1_x0 & rd_x0 -> vl unchanged (if new VLMAX < old vl, set vill instead); otherwise vl = min(AVL, VLMAX). vsetvl also clears vstart.
- External writes: each strobe loads its field from ext_csr_data (vxrm [1:0], vxsat [0], vs [10:9], vstart [VL_W-1:0], vl [VL_W-1:0], vtype full with legality check). Multiple strobes same cycle all apply.
- Priority per field, highest first: external write > vsetvl commit > vstart_wr > vstart_clr; vxsat_set ORs in unless external vxsat write same cycle.
- Any update of vtype/vl/vstart/vxrm/vxsat from a non-external source sets VS=Dirty (2'b11) unless VS==Off. External vsstatus write wins over the dirty update.
- While VS==Off: vset requests are still accepted and completed, and vs_off=1. Decode is responsible for trapping; this block never blocks the request.
- vlmax_q is recomputed combinationally from the registered vtype_q.
- Reset asserted mid-CALC: FSM returns to IDLE, no response is issued, and all state is reset.

Decomposition:
- riscv_v_pkg carries: vtype_t packed struct, vsew_e/vlmul_e enums, vs_state_e (OFF/INITIAL/CLEAN/DIRTY), VS_FIELD_LSB=9, and the function vlmax_f(vtype, VLEN).
- One sub-module: riscv_v_vtype_check. It is combinational: vtype in; legal flag, sanitized vtype and VLMAX out. It is shared by the external write path and the vsetvl path.

Test Plan:
- Reset (rst=0 then 1) -> vtype_q=32'h8000_0000, vl_q=0, vs_state=01, vset_ready=1.
- vsetvli AVL=20, vtype=0x10 (SEW32, LMUL1, VLEN128) -> rsp_valid 2 cycles later, vl=4, vlmax_q=4, vs_state=11.
- rs1_x0=1, rd_x0=0, vtype=0x03 (SEW8, LMUL8) -> vl=128. Then vtype=0x04 (reserved LMUL) -> vtype_q=0x8000_0000, vl=0.
- Same cycle: ext_wr_vxsat with data=0 and vxsat_set=1 -> vxsat_q=0. Next cycle vxsat_set=1 alone -> vxsat_q=1.
- Same cycle: vstart_wr with wdata=5 and ext_wr_vstart with data=9 -> vstart_q=9. Then vstart_clr -> 0.
- Reset pulse during CALC -> no rsp_valid, vl_q=0. Next request completes normally.
